rgb_pattern_gen: RTL
====================

# rgb_pattern_gen

Stream source for the RGB video pipeline. It generates a complete raster: pixel data, hsync/vsync/vde timing and a valid/ready handshake. It drives the input side of the RGB processing stage, replacing the camera/HDMI receiver path for bring-up and regression. Frame geometry is set by parameters; the pattern is selected at run time.

## Interface
- H_ACTIVE, 640: active pixels per line; must be a multiple of 8 and ≥ 8
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: hsync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: active lines per frame
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical front porch / sync / back porch (lines)
- All timing parameters ≥ 1. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- clk_i  in  1  clock; one clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- en_i  in  1  run request (level)
- mode_i  in  2  pattern select
- r_o, g_o, b_o  out  8 each  pixel data
- hsync_o, vsync_o, vde_o  out  1 each  timing, active-high
- valid_o  out  1  beat valid
- ready_i  in  1  downstream ready
- busy_o  out  1  generator in RUN state

## Operation
- FSM has two states, IDLE and RUN; reset state is IDLE.
- IDLE → RUN when en_i = 1. Counters h = 0, v = 0. mode_i is latched.
- RUN → IDLE when en_i = 0 and the beat h = H_TOTAL-1, v = V_TOTAL-1 is accepted. Frames always complete; en_i is not checked mid-frame.
- A beat is accepted when valid_o & ready_i. Each accepted beat advances the counters:
  - h advances; at H_TOTAL-1 it wraps to 0 and v advances.
  - v wraps from V_TOTAL-1 to 0.
- mode_i is re-latched only when the (0,0) beat is loaded, so a mode change never tears a frame.
- Beat fields, computed from (h, v):
  - vde = (h < H_ACTIVE) & (v < V_ACTIVE)
  - hsync = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vsync uses the same rule on v with the V parameters
  - r/g/b = 0 whenever vde = 0
- Patterns (active area, x = h + offset, wrapped mod H_ACTIVE):
  - 00 colour bars: 8 bars, each H_ACTIVE/8 wide. Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. Bar index comes from a bar counter; no divider.
  - 01 gray ramp: r = g = b = x[7:0]
  - 10 checkerboard: white if x[3] ^ v[3], else black
  - 11 solid 808080
- offset = 0 unless the Configuration feature is enabled.

## Timing
- All outputs are registered. Reset values:
  - r/g/b_o = 0, hsync_o = vsync_o = vde_o = 0, valid_o = 0, busy_o = 0
  - h = v = 0, offset = 0, latched mode = 00
- en_i sampled 1 at edge N (in IDLE) → valid_o = 1 and the (0,0) beat present after edge N; busy_o = 1 from the same edge.
- valid_o stays 1 throughout RUN; there are no bubbles. When ready_i = 1 every cycle, throughput is one beat per cycle.
- valid_o & !ready_i: all outputs hold stable until acceptance (AXI-style; valid_o never drops without acceptance).
- Last beat accepted with en_i = 0: after that edge, valid_o = 0, busy_o = 0, all data/timing outputs = 0.
- Last beat accepted with en_i = 1: the (0,0) beat of the next frame follows on the next cycle; there is no gap.
- rst_ni low at any time, including mid-beat with valid_o high and ready_i low: immediate return to reset values. No partial frame resumes.

## Configuration
- RGB_PATGEN_SCROLL_EN defined:
  - offset register increments by 1 at each frame wrap (v: V_TOTAL-1 → 0), wrapping H_ACTIVE-1 → 0.
  - offset resets to 0 on reset and on IDLE → RUN.
- RGB_PATGEN_SCROLL_EN undefined: offset is constant 0 and its register is not synthesized; pattern is static.

## Test plan
All scenarios use H_ACTIVE=16, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 (H_TOTAL 22, V_TOTAL 7, 154 beats/frame).
- Reset, then en_i=1, mode 00, ready_i=1 → first beat one cycle after en_i: rgb FFFFFF, vde=1. Pixels 2–3 are FFFF00, pixel 14 is 000000. hsync=1 at h=18,19. Exactly 154 beats per frame.
- ready_i toggled randomly → accepted beat sequence identical to the ready_i=1 run; outputs stable while stalled.
- en_i dropped at beat 50 → frame completes (154 beats total), then valid_o=0, busy_o=0; no beat after the wrap.
- mode_i changed 00→01 mid-frame → current frame stays bars; next frame shows ramp: pixel h=5 reads 050505.
- rst_ni pulsed low while valid_o=1, ready_i=0 → all outputs 0 immediately. With en_i=1 after release, restart at (0,0).
- With RGB_PATGEN_SCROLL_EN, mode 01 → frame 2 pixel 0 reads 010101; frame 17 pixel 0 reads 000000 (wrap at 16).

Source files
------------

// File: rtl/rgb_pattern_gen.sv
// Raster test-pattern source: colour bars, gray ramp, checkerboard or solid gray with
// hsync/vsync/vde timing over a valid/ready stream. Define RGB_PATGEN_SCROLL_EN to scroll per frame.
module rgb_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       vde_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = ($clog2(V_TOTAL) > 4) ? $clog2(V_TOTAL) : 4;
  localparam int XW      = ($clog2(H_ACTIVE) > 8) ? $clog2(H_ACTIVE) : 8;
  localparam int BW      = H_ACTIVE / 8;
  localparam int BCW     = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]  H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]  HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]  V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]  VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [XW-1:0]  X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [BCW-1:0] CNT_LAST = BCW'(BW - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Pattern x position kept together with its bar index and position inside the bar,
  // so the bar colour never needs a divide.
  typedef struct packed {
    logic [XW-1:0]  x;
    logic [2:0]     bar;
    logic [BCW-1:0] cnt;
  } pos_t;

  function automatic pos_t pos_adv(input pos_t p);
    pos_t n;
    n = p;
    if (p.x == X_LAST) begin
      n = '0;
    end else begin
      n.x = p.x + XW'(1);
      if (p.cnt == CNT_LAST) begin
        n.cnt = '0;
        n.bar = p.bar + 3'd1;
      end else begin
        n.cnt = p.cnt + BCW'(1);
      end
    end
    return n;
  endfunction

  function automatic logic [23:0] bar_rgb(input logic [2:0] b);
    case (b)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  pos_t           pos_q, pos_d;
  logic [1:0]     mode_q, mode_d;
  logic [23:0]    rgb_q, rgb_d;
  logic           hs_q, hs_d, vs_q, vs_d, vde_q, vde_d;

  logic           start, step, frame_wrap, stop, last_beat;
  logic [HW-1:0]  nh;
  logic [VW-1:0]  nv;
  pos_t           npos;
  logic [1:0]     nmode;
  logic [23:0]    rgb_n;
  logic           vde_n;

  assign last_beat = (h_q == H_LAST) && (v_q == V_LAST);

  // NOTE: every signal gets a default at the top of an always_comb block; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    step       = 1'b0;
    frame_wrap = 1'b0;
    stop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (ready_i) begin
          if (!last_beat) begin
            step = 1'b1;
          end else if (en_i) begin
            frame_wrap = 1'b1;
          end else begin
            stop    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RGB_PATGEN_SCROLL_EN
  pos_t off_q, off_d;

  always_comb begin
    off_d = off_q;
    if (start) begin
      off_d = '0;
    end else if (frame_wrap) begin
      off_d = pos_adv(off_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) off_q <= '0;
    else         off_q <= off_d;
  end
`else
  pos_t off_d;
  assign off_d = '0;
`endif

  // Coordinates and fields of the beat that would be presented next.
  always_comb begin
    nh    = h_q + HW'(1);
    nv    = v_q;
    npos  = pos_adv(pos_q);
    nmode = mode_q;
    if (start || frame_wrap) begin
      nh    = '0;
      nv    = '0;
      npos  = off_d;
      nmode = mode_i;
    end else if (h_q == H_LAST) begin
      nh   = '0;
      nv   = v_q + VW'(1);
      npos = off_d;
    end

    vde_n = (nh < H_ACT) && (nv < V_ACT);
    case (nmode)
      2'b00:   rgb_n = bar_rgb(npos.bar);
      2'b01:   rgb_n = {3{npos.x[7:0]}};
      2'b10:   rgb_n = (npos.x[3] ^ nv[3]) ? 24'hFFFFFF : 24'h000000;
      default: rgb_n = 24'h808080;
    endcase
    if (!vde_n) rgb_n = '0;

    h_d    = h_q;
    v_d    = v_q;
    pos_d  = pos_q;
    mode_d = mode_q;
    rgb_d  = rgb_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    vde_d  = vde_q;
    if (start || step || frame_wrap) begin
      h_d    = nh;
      v_d    = nv;
      pos_d  = npos;
      mode_d = nmode;
      rgb_d  = rgb_n;
      hs_d   = (nh >= HS_BEG) && (nh < HS_END);
      vs_d   = (nv >= VS_BEG) && (nv < VS_END);
      vde_d  = vde_n;
    end else if (stop) begin
      h_d   = '0;
      v_d   = '0;
      pos_d = '0;
      rgb_d = '0;
      hs_d  = 1'b0;
      vs_d  = 1'b0;
      vde_d = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      pos_q   <= '0;
      mode_q  <= 2'b00;
      rgb_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      vde_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pos_q   <= pos_d;
      mode_q  <= mode_d;
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      vde_q   <= vde_d;
    end
  end

  assign r_o     = rgb_q[23:16];
  assign g_o     = rgb_q[15:8];
  assign b_o     = rgb_q[7:0];
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;
  assign vde_o   = vde_q;
  assign valid_o = (state_q == RUN);
  assign busy_o  = (state_q == RUN);

endmodule
